proc_control: RTL and testbench
===============================

# proc_control

Control sequencer for the 16-bit simple processor datapath (registers R0–R7, A, G, add/sub unit, bus mux, ADDR/DOUT registers, synchronous memory). It fetches each instruction from memory using R7 as program counter, then issues the per-step mux selects and register enables that execute it. It owns no datapath registers; it is instantiated beside the datapath inside the processor top level.

## Interface
Parameters:
- `MEM_LAT`, 1, memory read latency in cycles; fixed at 1, and only 1 is supported.

Ports:
- `Clock`  in  1  system clock, rising-edge.
- `Reset`  in  1  synchronous, active-high reset.
- `Run`  in  1  sequencing enable. 0 = stall in the current step.
- `IR`  in  9  instruction register contents `{III, XXX, YYY}`, held by the datapath.
- `G_nz`  in  1  high when G ≠ 0.
- `IRin`  out  1  load IR from DIN.
- `Rin`  out  8  one-hot register write enables R0–R7.
- `Rout`  out  8  one-hot bus select R0–R7.
- `Gout`, `DINout`  out  1 each  bus select for G and for DIN.
- `Ain`, `Gin`  out  1 each  load A and load G.
- `AddSub`  out  1  0 = add, 1 = subtract.
- `ADDRin`, `DOUTin`  out  1 each  load ADDR or DOUT from the bus.
- `W_D`  out  1  memory write enable.
- `incr_pc`  out  1  increment R7.
- `Done`  out  1  single-cycle pulse on the last step of an instruction.
- `Tstep`  out  3  current step encoding, for debug.

## Operation
- Steps: F0=0, F1=1, F2=2, E1=3, E2=4, E3=5. A registered state machine holds the step. All outputs are combinational decodes of the step, `IR` and `G_nz`.
- Outputs are gated by `Run & ~Reset`. At most one bus source and at most one `Rin` bit are active in any cycle.
- Fetch sequence:
  - F0: `Rout[7]`, `ADDRin`.
  - F1: `incr_pc`. Memory latency cycle.
  - F2: `DINout`, `IRin`.
  - Then go to E1.
- Execute sequence by opcode (X = IR[5:3], Y = IR[2:0]):
  - 000 mv: E1 `Rout[Y]`, `Rin[X]`, `Done`.
  - 001 mvi:
    - E1 `Rout[7]`, `ADDRin`.
    - E2 `incr_pc`.
    - E3 `DINout`, `Rin[X]`, `Done`.
  - 010 add:
    - E1 `Rout[X]`, `Ain`.
    - E2 `Rout[Y]`, `Gin`, `AddSub`=0.
    - E3 `Gout`, `Rin[X]`, `Done`.
  - 011 sub: same as add, with `AddSub`=1 in E2.
  - 100 ld:
    - E1 `Rout[Y]`, `ADDRin`.
    - E2 no enables (latency).
    - E3 `DINout`, `Rin[X]`, `Done`.
  - 101 st:
    - E1 `Rout[Y]`, `ADDRin`.
    - E2 `Rout[X]`, `DOUTin`.
    - E3 `W_D`, `Done`.
  - 110 mvnz: E1 `Rout[Y]` and `Rin[X]` only if `G_nz`. `Done` is asserted regardless.
  - 111 reserved: E1 `Done` only (no-op).
- After any step that asserts `Done`, the next step is F0.
- Writing R7 (X=7) is legal and acts as a jump. The next F0 uses the new R7 value.

## Timing
- Reset: when `Reset`=1 at a rising edge, the step becomes F0. While `Reset` is high, every output is 0 and `Tstep`=0. Reset mid-instruction abandons it with no further enables.
- Run: with `Run`=0 at an edge, the step is held and all enables are 0. The step resumes unchanged when `Run` returns to 1. `Tstep` always shows the held step.
- Latency from F0 to `Done`:
  - mv, mvnz, reserved: 4 cycles.
  - mvi, add, sub, ld, st: 6 cycles.
- `IR` is sampled combinationally in E1–E3 only. It is stable because `IRin` fires only in F2.
- `G_nz` is sampled in mvnz E1 only.
- `incr_pc` never coincides with `Rin[7]`.

## Test plan
- Reset and stall: `Reset`=1 for 2 cycles with `Run`=1. All outputs are 0 and `Tstep`=0. Release `Reset`: the first cycle shows F0 with `Rout`=8'h80 and `ADDRin`=1. Drop `Run` in F1: `Tstep` holds at 1 and all enables are 0.
- mvi then add: memory holds mvi R0,#5 / mvi R1,#3 / add R0,R1. R0 ends at 8 after 18 active cycles, and R7 ends at 5. `Done` pulses on cycles 6, 12 and 18.
- sub and mvnz: R0=8, R1=8, then sub R0,R1 gives G=0. A following mvnz R7,R2 does not change R7 and `Rin` stays 0. Repeat with G=1: R7 takes R2 and the next fetch address equals R2.
- ld and st: st R3,R4 with R3=16'h00AB and R4=16'h0020 asserts `W_D` exactly once, in E3, with ADDR=16'h0020. Then ld R5,R4 gives R5=16'h00AB.
- Reset mid-instruction: assert `Reset` in add E2. No `Gin` or `Rin` pulse follows. After release, fetch restarts at F0. R7 is unaffected by the control block; the datapath clears it.
- Reserved opcode 111: step sequence is F0→F1→F2→E1→F0. `Done` pulses in E1 and no other enable is asserted in E1.

Source files
------------

// File: rtl/proc_control.sv
// Instruction sequencer for the 16-bit simple processor: fetches each instruction
// through R7, then drives the per-step mux selects and register enables.
module proc_control #(
  parameter int MEM_LAT = 1
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Run,
  input  logic [8:0] IR,
  input  logic       G_nz,
  output logic       IRin,
  output logic [7:0] Rin,
  output logic [7:0] Rout,
  output logic       Gout,
  output logic       DINout,
  output logic       Ain,
  output logic       Gin,
  output logic       AddSub,
  output logic       ADDRin,
  output logic       DOUTin,
  output logic       W_D,
  output logic       incr_pc,
  output logic       Done,
  output logic [2:0] Tstep
);

  if (MEM_LAT != 1) begin : g_bad_latency
    $error("proc_control supports only MEM_LAT == 1");
  end

  typedef enum logic [2:0] {
    F0 = 3'd0,
    F1 = 3'd1,
    F2 = 3'd2,
    E1 = 3'd3,
    E2 = 3'd4,
    E3 = 3'd5
  } step_t;

  step_t      step;
  step_t      step_nxt;
  logic       active;
  logic [2:0] op;
  logic [2:0] rx;
  logic [2:0] ry;

  // Run is the only flow control: a step advances on an edge where Run=1,
  // and every enable is held low in any cycle where Run=0 or Reset=1.
  assign active = Run & ~Reset;
  assign op     = IR[8:6];
  assign rx     = IR[5:3];
  assign ry     = IR[2:0];

  // Tstep doubles as the debug view of the FSM state.
  assign Tstep = Reset ? 3'd0 : step;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      step <= F0;
    end else if (Run) begin
      step <= step_nxt;
    end
  end

  always_comb begin
    step_nxt = F0;
    IRin     = 1'b0;
    Rin      = 8'h00;
    Rout     = 8'h00;
    Gout     = 1'b0;
    DINout   = 1'b0;
    Ain      = 1'b0;
    Gin      = 1'b0;
    AddSub   = 1'b0;
    ADDRin   = 1'b0;
    DOUTin   = 1'b0;
    W_D      = 1'b0;
    incr_pc  = 1'b0;
    Done     = 1'b0;

    case (step)
      F0: begin
        step_nxt = F1;
        Rout[7]  = 1'b1;
        ADDRin   = 1'b1;
      end
      F1: begin
        step_nxt = F2;
        incr_pc  = 1'b1;
      end
      F2: begin
        step_nxt = E1;
        DINout   = 1'b1;
        IRin     = 1'b1;
      end
      E1: begin
        // mv, mvnz and the reserved opcode complete in a single execute step.
        if (op == 3'b000 || op == 3'b110 || op == 3'b111) step_nxt = F0;
        else step_nxt = E2;
        case (op)
          3'b000: begin
            Rout[ry] = 1'b1;
            Rin[rx]  = 1'b1;
            Done     = 1'b1;
          end
          3'b001: begin
            Rout[7] = 1'b1;
            ADDRin  = 1'b1;
          end
          3'b010, 3'b011: begin
            Rout[rx] = 1'b1;
            Ain      = 1'b1;
          end
          3'b100, 3'b101: begin
            Rout[ry] = 1'b1;
            ADDRin   = 1'b1;
          end
          3'b110: begin
            if (G_nz) begin
              Rout[ry] = 1'b1;
              Rin[rx]  = 1'b1;
            end
            Done = 1'b1;
          end
          default: Done = 1'b1;
        endcase
      end
      E2: begin
        step_nxt = E3;
        case (op)
          3'b001: incr_pc = 1'b1;
          3'b010, 3'b011: begin
            Rout[ry] = 1'b1;
            Gin      = 1'b1;
            AddSub   = op[0];
          end
          3'b101: begin
            Rout[rx] = 1'b1;
            DOUTin   = 1'b1;
          end
          default: ;
        endcase
      end
      E3: begin
        step_nxt = F0;
        Done     = 1'b1;
        case (op)
          3'b001, 3'b100: begin
            DINout  = 1'b1;
            Rin[rx] = 1'b1;
          end
          3'b010, 3'b011: begin
            Gout    = 1'b1;
            Rin[rx] = 1'b1;
          end
          3'b101:  W_D = 1'b1;
          default: ;
        endcase
      end
      default: step_nxt = F0;
    endcase

    if (!active) begin
      IRin    = 1'b0;
      Rin     = 8'h00;
      Rout    = 8'h00;
      Gout    = 1'b0;
      DINout  = 1'b0;
      Ain     = 1'b0;
      Gin     = 1'b0;
      AddSub  = 1'b0;
      ADDRin  = 1'b0;
      DOUTin  = 1'b0;
      W_D     = 1'b0;
      incr_pc = 1'b0;
      Done    = 1'b0;
    end
  end

endmodule

// File: tb/tb_proc_control.sv
// Directed bench for proc_control: per-step control words of every opcode,
// reset/stall behaviour and back-to-back Done timing.
module tb_proc_control;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       Run;
  logic [8:0] IR;
  logic       G_nz;
  logic       IRin;
  logic [7:0] Rin;
  logic [7:0] Rout;
  logic       Gout;
  logic       DINout;
  logic       Ain;
  logic       Gin;
  logic       AddSub;
  logic       ADDRin;
  logic       DOUTin;
  logic       W_D;
  logic       incr_pc;
  logic       Done;
  logic [2:0] Tstep;

  int checks = 0;
  int fails  = 0;

  proc_control #(.MEM_LAT(1)) dut (
    .Clock(Clock), .Reset(Reset), .Run(Run), .IR(IR), .G_nz(G_nz),
    .IRin(IRin), .Rin(Rin), .Rout(Rout), .Gout(Gout), .DINout(DINout),
    .Ain(Ain), .Gin(Gin), .AddSub(AddSub), .ADDRin(ADDRin), .DOUTin(DOUTin),
    .W_D(W_D), .incr_pc(incr_pc), .Done(Done), .Tstep(Tstep)
  );

  // Clock / reset block
  always #5 Clock = ~Clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Observed control word: {Rin, Rout, flags}
  logic [26:0] obs;
  assign obs = {Rin, Rout, IRin, Gout, DINout, Ain, Gin, AddSub, ADDRin, DOUTin, W_D, incr_pc, Done};

  localparam logic [10:0] IRIN   = 11'h400;
  localparam logic [10:0] GOUT   = 11'h200;
  localparam logic [10:0] DINOUT = 11'h100;
  localparam logic [10:0] AIN    = 11'h080;
  localparam logic [10:0] GIN    = 11'h040;
  localparam logic [10:0] ADDSUB = 11'h020;
  localparam logic [10:0] ADDRIN = 11'h010;
  localparam logic [10:0] DOUTIN = 11'h008;
  localparam logic [10:0] WD     = 11'h004;
  localparam logic [10:0] INCPC  = 11'h002;
  localparam logic [10:0] DONE   = 11'h001;

  localparam logic [26:0] W_F0 = {8'h00, 8'h80, ADDRIN};
  localparam logic [26:0] W_F1 = {8'h00, 8'h00, INCPC};
  localparam logic [26:0] W_F2 = {8'h00, 8'h00, IRIN | DINOUT};

  typedef struct {
    string       nm;
    logic [8:0]  ir;
    logic        gnz;
    int          n;
    logic [26:0] e[3];
  } instr_t;

  function automatic logic [26:0] ew(input logic [7:0] rin, input logic [7:0] rout,
                                     input logic [10:0] f);
    return {rin, rout, f};
  endfunction

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // Driver / checker tasks
  task automatic test_reset();
    Reset = 1'b1; Run = 1'b1; IR = 9'h000; G_nz = 1'b0;
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if (obs !== 27'h0 || Tstep !== 3'd0) begin
        fails++;
        $display("FAIL reset_hold cycle %0d: got word %h step %0d, want 0 step 0", c, obs, Tstep);
      end
    end
    Reset = 1'b0;
    #1;
    checks++;
    if (obs !== W_F0 || Tstep !== 3'd0) begin
      fails++;
      $display("FAIL reset_release: got %h step %0d, want %h step 0", obs, Tstep, W_F0);
    end
    tick();
    checks++;
    if (obs !== W_F1 || Tstep !== 3'd1) begin
      fails++;
      $display("FAIL reset_f1: got %h step %0d, want %h step 1", obs, Tstep, W_F1);
    end
    Run = 1'b0;
    #1;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (obs !== 27'h0 || Tstep !== 3'd1) begin
        fails++;
        $display("FAIL stall_f1 cycle %0d: got %h step %0d, want 0 step 1", c, obs, Tstep);
      end
      if (c < 2) tick();
    end
    Run = 1'b1;
    #1;
    checks++;
    if (obs !== W_F1 || Tstep !== 3'd1) begin
      fails++;
      $display("FAIL stall_resume: got %h step %0d, want %h step 1", obs, Tstep, W_F1);
    end
    Reset = 1'b1;
    #1;
    checks++;
    if (obs !== 27'h0 || Tstep !== 3'd0) begin
      fails++;
      $display("FAIL reset_in_f1: got %h step %0d, want 0 step 0", obs, Tstep);
    end
    tick();
    Reset = 1'b0;
    #1;
  endtask

  task automatic test_opcodes(input string feat, input instr_t t[]);
    for (int i = 0; i < t.size(); i++) begin
      IR   = t[i].ir;
      G_nz = t[i].gnz;
      for (int s = 0; s < t[i].n; s++) begin
        logic [26:0] want;
        want = (s == 0) ? W_F0 : (s == 1) ? W_F1 : (s == 2) ? W_F2 : t[i].e[s-3];
        checks++;
        if (obs !== want || Tstep !== 3'(s)) begin
          fails++;
          $display("FAIL %s/%s step %0d: got %h step %0d, want %h step %0d",
                   feat, t[i].nm, s, obs, Tstep, want, s);
        end
        tick();
      end
      checks++;
      if (Tstep !== 3'd0) begin
        fails++;
        $display("FAIL %s/%s return_f0: got step %0d, want 0", feat, t[i].nm, Tstep);
      end
    end
  endtask

  task automatic test_mv();
    instr_t t[];
    t = new[2];
    t[0] = '{"mv_r2_r5", 9'b000_010_101, 1'b0, 4, '{ew(8'h04, 8'h20, DONE), 27'h0, 27'h0}};
    t[1] = '{"mv_r7_r0", 9'b000_111_000, 1'b0, 4, '{ew(8'h80, 8'h01, DONE), 27'h0, 27'h0}};
    test_opcodes("mv", t);
  endtask

  task automatic test_mvi();
    instr_t t[];
    t = new[2];
    t[0] = '{"mvi_r0", 9'b001_000_000, 1'b0, 6,
             '{ew(8'h00, 8'h80, ADDRIN), ew(8'h00, 8'h00, INCPC), ew(8'h01, 8'h00, DINOUT | DONE)}};
    t[1] = '{"mvi_r6", 9'b001_110_011, 1'b1, 6,
             '{ew(8'h00, 8'h80, ADDRIN), ew(8'h00, 8'h00, INCPC), ew(8'h40, 8'h00, DINOUT | DONE)}};
    test_opcodes("mvi", t);
  endtask

  task automatic test_alu();
    instr_t t[];
    t = new[2];
    t[0] = '{"add_r0_r1", 9'b010_000_001, 1'b0, 6,
             '{ew(8'h00, 8'h01, AIN), ew(8'h00, 8'h02, GIN), ew(8'h01, 8'h00, GOUT | DONE)}};
    t[1] = '{"sub_r3_r6", 9'b011_011_110, 1'b0, 6,
             '{ew(8'h00, 8'h08, AIN), ew(8'h00, 8'h40, GIN | ADDSUB), ew(8'h08, 8'h00, GOUT | DONE)}};
    test_opcodes("alu", t);
  endtask

  task automatic test_mem();
    instr_t t[];
    t = new[2];
    t[0] = '{"st_r3_r4", 9'b101_011_100, 1'b0, 6,
             '{ew(8'h00, 8'h10, ADDRIN), ew(8'h00, 8'h08, DOUTIN), ew(8'h00, 8'h00, WD | DONE)}};
    t[1] = '{"ld_r5_r4", 9'b100_101_100, 1'b0, 6,
             '{ew(8'h00, 8'h10, ADDRIN), 27'h0, ew(8'h20, 8'h00, DINOUT | DONE)}};
    test_opcodes("mem", t);
  endtask

  task automatic test_mvnz();
    instr_t t[];
    t = new[2];
    t[0] = '{"mvnz_g0", 9'b110_111_010, 1'b0, 4, '{ew(8'h00, 8'h00, DONE), 27'h0, 27'h0}};
    t[1] = '{"mvnz_g1", 9'b110_111_010, 1'b1, 4, '{ew(8'h80, 8'h04, DONE), 27'h0, 27'h0}};
    test_opcodes("mvnz", t);
  endtask

  task automatic test_reserved();
    instr_t t[];
    t = new[1];
    t[0] = '{"op111", 9'b111_101_011, 1'b1, 4, '{ew(8'h00, 8'h00, DONE), 27'h0, 27'h0}};
    test_opcodes("reserved", t);
  endtask

  task automatic test_stall_exec();
    IR = 9'b011_000_001;
    for (int c = 0; c < 4; c++) tick();
    Run = 1'b0;
    #1;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (obs !== 27'h0 || Tstep !== 3'd4) begin
        fails++;
        $display("FAIL stall_e2 cycle %0d: got %h step %0d, want 0 step 4", c, obs, Tstep);
      end
      tick();
    end
    Run = 1'b1;
    #1;
    checks++;
    if (obs !== ew(8'h00, 8'h02, GIN | ADDSUB) || Tstep !== 3'd4) begin
      fails++;
      $display("FAIL stall_e2_resume: got %h step %0d, want %h step 4",
               obs, Tstep, ew(8'h00, 8'h02, GIN | ADDSUB));
    end
    tick();
    checks++;
    if (obs !== ew(8'h01, 8'h00, GOUT | DONE) || Tstep !== 3'd5) begin
      fails++;
      $display("FAIL stall_e3: got %h step %0d, want %h step 5", obs, Tstep, ew(8'h01, 8'h00, GOUT | DONE));
    end
    tick();
  endtask

  task automatic test_reset_mid();
    IR = 9'b010_000_001;
    for (int c = 0; c < 4; c++) tick();
    checks++;
    if (Tstep !== 3'd4) begin
      fails++;
      $display("FAIL reset_mid_reach_e2: got step %0d, want 4", Tstep);
    end
    Reset = 1'b1;
    #1;
    for (int c = 0; c < 2; c++) begin
      checks++;
      if (obs !== 27'h0 || Tstep !== 3'd0) begin
        fails++;
        $display("FAIL reset_mid_hold cycle %0d: got %h step %0d, want 0 step 0", c, obs, Tstep);
      end
      tick();
    end
    Reset = 1'b0;
    #1;
    checks++;
    if (obs !== W_F0 || Tstep !== 3'd0) begin
      fails++;
      $display("FAIL reset_mid_f0: got %h step %0d, want %h step 0", obs, Tstep, W_F0);
    end
    tick();
    checks++;
    if (obs !== W_F1 || Tstep !== 3'd1) begin
      fails++;
      $display("FAIL reset_mid_f1: got %h step %0d, want %h step 1", obs, Tstep, W_F1);
    end
    IR = 9'b111_000_000;
    tick();
    tick();
    tick();
  endtask

  task automatic test_back_to_back();
    logic [8:0] prog[3];
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int         pc;
    prog   = '{9'b001_000_000, 9'b001_001_000, 9'b010_000_001};
    exp_q  = '{8'd6, 8'd12, 8'd18};
    pc     = 0;
    IR     = 9'b111_111_111;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      if (Tstep == 3'd2 && pc < 3) begin
        IR = prog[pc];
        pc++;
      end
      #1;
      if (Done === 1'b1) got_q.push_back(8'(cyc));
      tick();
      if (cyc == 18) break;
    end
    checks++;
    if (got_q.size() !== exp_q.size()) begin
      fails++;
      $display("FAIL b2b_done_count: got %0d pulses, want %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL b2b_done_cycle %0d: got %0d, want %0d", i,
                 (i < got_q.size()) ? got_q[i] : 8'd0, exp_q[i]);
      end
    end
    checks++;
    if (Tstep !== 3'd0) begin
      fails++;
      $display("FAIL b2b_end_step: got %0d, want 0", Tstep);
    end
  endtask

  initial begin
    test_reset();
    test_mv();
    test_mvi();
    test_alu();
    test_mem();
    test_mvnz();
    test_reserved();
    test_stall_exec();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
    $finish;
  end

endmodule
